// File: rtl/collision_resolver.sv
// Sequential collision resolver: walks the upper triangle of the pair matrix and applies
// a per-axis 1D elastic exchange to each colliding pair using a restoring divider.
module collision_resolver #(
  parameter int SPRITES    = 9,
  parameter int DIMENSIONS = 2,
  parameter int WIDTH      = 32
) (
  input  logic                                          clk,
  input  logic                                          rst_l,
  input  logic                                          start,
  input  logic [SPRITES-1:0][SPRITES-1:0]               collision_matrix,
  input  logic [SPRITES-1:0][DIMENSIONS-1:0][WIDTH-1:0] velocities,
  input  logic [SPRITES-1:0][WIDTH/2-1:0]               masses,
  output logic                                          busy,
  output logic                                          done,
  output logic [SPRITES-1:0][DIMENSIONS-1:0][WIDTH-1:0] new_velocities
);
  localparam int MASS_W = WIDTH / 2;
  localparam int NUM_W  = 3 * WIDTH / 2 + 3;
  localparam int DEN_W  = MASS_W + 1;
  localparam int IDX_W  = $clog2(SPRITES);
  localparam int D_W    = (DIMENSIONS > 1) ? $clog2(DIMENSIONS) : 1;
  localparam int CNT_W  = $clog2(NUM_W);

  localparam logic [IDX_W-1:0] LAST_I   = IDX_W'(SPRITES - 2);
  localparam logic [IDX_W-1:0] LAST_J   = IDX_W'(SPRITES - 1);
  localparam logic [D_W-1:0]   TOP_D    = D_W'(DIMENSIONS - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_W - 1);
  localparam logic [NUM_W-1:0] POS_LIM  = {{(NUM_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic [NUM_W-1:0] NEG_LIM  = {{(NUM_W-WIDTH){1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    ST_IDLE, ST_SCAN, ST_SETUP, ST_DIV, ST_WRITE, ST_DONE
  } state_t;

  state_t state, nxt;

  logic [SPRITES-1:0][SPRITES-1:0]               work_mat;
  logic [SPRITES-1:0][DIMENSIONS-1:0][WIDTH-1:0] work_vel;
  logic [SPRITES-1:0][MASS_W-1:0]                work_mass;
  logic [SPRITES-1:0][DIMENSIONS-1:0][WIDTH-1:0] vel_upd;
  logic [1:0][DIMENSIONS-1:0][WIDTH-1:0]         res_buf;

  logic [IDX_W-1:0] pi, pj;
  logic [D_W-1:0]   d_idx;
  logic             sel_b;
  logic [CNT_W-1:0] cnt;
  logic [NUM_W-1:0] num_mag;
  logic             neg;
  logic [DEN_W-1:0] den;
  logic [DEN_W-1:0] rem;
  logic [NUM_W-1:0] quo;

  logic                    pair_hit, last_pair, div_last;
  logic signed [NUM_W-1:0] num_c;
  logic [NUM_W-1:0]        mag_c;
  logic [DEN_W-1:0]        den_c;
  logic [DEN_W:0]          trial, diff;
  logic                    ge;
  logic [DEN_W-1:0]        rem_nx;
  logic [NUM_W-1:0]        quo_nx;
  logic signed [WIDTH-1:0] sat_res;

  function automatic logic signed [WIDTH-1:0] saturate(input logic [NUM_W-1:0] mag,
                                                       input logic negative);
    logic [WIDTH-1:0] low;
    low = mag[WIDTH-1:0];
    if (!negative && (mag > POS_LIM)) return {1'b0, {(WIDTH-1){1'b1}}};
    if (negative && (mag > NEG_LIM))  return {1'b1, {(WIDTH-1){1'b0}}};
    return negative ? signed'(-low) : signed'(low);
  endfunction

  assign pair_hit  = work_mat[pi][pj] && (work_mass[pi] != '0) && (work_mass[pj] != '0);
  assign last_pair = (pi == LAST_I) && (pj == LAST_J);
  assign div_last  = (cnt == LAST_CNT);

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) state <= ST_IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt  = state;
    busy = 1'b0;
    done = 1'b0;
    case (state)
      ST_IDLE:  if (start) nxt = ST_SCAN;
      ST_SCAN: begin
        busy = 1'b1;
        if (pair_hit)       nxt = ST_SETUP;
        else if (last_pair) nxt = ST_DONE;
      end
      ST_SETUP: begin
        busy = 1'b1;
        nxt  = ST_DIV;
      end
      ST_DIV: begin
        busy = 1'b1;
        if (div_last) nxt = (sel_b && (d_idx == '0)) ? ST_WRITE : ST_SETUP;
      end
      ST_WRITE: begin
        busy = 1'b1;
        nxt  = last_pair ? ST_DONE : ST_SCAN;
      end
      ST_DONE: begin
        done = 1'b1;
        nxt  = ST_IDLE;
      end
      default:  nxt = ST_IDLE;
    endcase
  end

  // Numerator for the current target sprite: B is A with the pair roles swapped.
  always_comb begin
    logic [WIDTH-1:0]        va, vb;
    logic [MASS_W-1:0]       ma, mb;
    logic signed [NUM_W-1:0] ma_s, mb_s, va_s, vb_s;
    va    = sel_b ? work_vel[pj][d_idx] : work_vel[pi][d_idx];
    vb    = sel_b ? work_vel[pi][d_idx] : work_vel[pj][d_idx];
    ma    = sel_b ? work_mass[pj] : work_mass[pi];
    mb    = sel_b ? work_mass[pi] : work_mass[pj];
    ma_s  = signed'({{(NUM_W-MASS_W){1'b0}}, ma});
    mb_s  = signed'({{(NUM_W-MASS_W){1'b0}}, mb});
    va_s  = signed'({{(NUM_W-WIDTH){va[WIDTH-1]}}, va});
    vb_s  = signed'({{(NUM_W-WIDTH){vb[WIDTH-1]}}, vb});
    num_c = (ma_s - mb_s) * va_s + (mb_s <<< 1) * vb_s;
    mag_c = num_c[NUM_W-1] ? unsigned'(-num_c) : unsigned'(num_c);
    den_c = {1'b0, ma} + {1'b0, mb};
  end

  always_comb begin
    trial   = {rem, num_mag[NUM_W-1]};
    diff    = trial - {1'b0, den};
    ge      = (trial >= {1'b0, den});
    rem_nx  = ge ? diff[DEN_W-1:0] : trial[DEN_W-1:0];
    quo_nx  = {quo[NUM_W-2:0], ge};
    sat_res = saturate(quo_nx, neg);
  end

  always_comb begin
    vel_upd = work_vel;
    if (state == ST_WRITE) begin
      vel_upd[pi] = res_buf[0];
      vel_upd[pj] = res_buf[1];
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      work_mat       <= '0;
      work_vel       <= '0;
      work_mass      <= '0;
      res_buf        <= '0;
      pi             <= '0;
      pj             <= '0;
      d_idx          <= '0;
      sel_b          <= 1'b0;
      cnt            <= '0;
      num_mag        <= '0;
      neg            <= 1'b0;
      den            <= '0;
      rem            <= '0;
      quo            <= '0;
      new_velocities <= '0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          work_mat  <= collision_matrix;
          work_vel  <= velocities;
          work_mass <= masses;
          pi        <= '0;
          pj        <= IDX_W'(1);
        end
        ST_SCAN: begin
          if (pair_hit) begin
            d_idx <= TOP_D;
            sel_b <= 1'b0;
          end else if (!last_pair) begin
            if (pj == LAST_J) begin
              pi <= pi + IDX_W'(1);
              pj <= pi + IDX_W'(2);
            end else begin
              pj <= pj + IDX_W'(1);
            end
          end
        end
        ST_SETUP: begin
          num_mag <= mag_c;
          neg     <= num_c[NUM_W-1];
          den     <= den_c;
          rem     <= '0;
          quo     <= '0;
          cnt     <= '0;
        end
        ST_DIV: begin
          num_mag <= {num_mag[NUM_W-2:0], 1'b0};
          rem     <= rem_nx;
          quo     <= quo_nx;
          cnt     <= cnt + CNT_W'(1);
          if (div_last) begin
            res_buf[sel_b][d_idx] <= sat_res;
            if (sel_b) begin
              sel_b <= 1'b0;
              d_idx <= d_idx - D_W'(1);
            end else begin
              sel_b <= 1'b1;
            end
          end
        end
        ST_WRITE: begin
          work_vel <= vel_upd;
          if (!last_pair) begin
            if (pj == LAST_J) begin
              pi <= pi + IDX_W'(1);
              pj <= pi + IDX_W'(2);
            end else begin
              pj <= pj + IDX_W'(1);
            end
          end
        end
        default: ;
      endcase
      // Publish on entry to DONE so the outputs are valid in the done cycle.
      if (nxt == ST_DONE) new_velocities <= vel_upd;
    end
  end

endmodule
